// File: rtl/phy_rx_serial_paralelo.sv
// Receive-side serial-to-parallel converter for one PHY lane.
// Finds the COM symbol at any bit offset, locks byte alignment, then
// emits each byte with a valid flag (COM bytes are idle fill).
//
// Ports:
//   clk_32f     in   bit clock, rising edge
//   reset_L     in   asynchronous active-low reset
//   data_in     in   serial bit stream, MSB first
//   data_out    out  [7:0] last completed non-idle byte after lock
//   valid_out   out  data_out holds a data byte (not COM)
//   byte_strobe out  one-cycle pulse per byte boundary while locked
//   active      out  byte alignment locked
module phy_rx_serial_paralelo #(
    parameter logic [7:0] COM       = 8'hBC,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] COM_TARGET = COM_COUNT[3:0];

    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] w;

    // Candidate word includes the bit on the line this cycle, so a
    // byte is judged on the same edge its last bit is sampled.
    assign w = {sr[6:0], data_in};

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SEARCH;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr <= w;
            unique case (state)
                SEARCH: begin
                    byte_strobe <= 1'b0;
                    bit_cnt     <= 3'd0;
                    com_cnt     <= 4'd0;
                    if (w == COM) begin
                        if (COM_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state   <= ALIGN;
                            com_cnt <= 4'd1;
                        end
                    end
                end
                ALIGN: begin
                    byte_strobe <= 1'b0;
                    bit_cnt     <= bit_cnt + 3'd1;
                    // Only byte-boundary words count toward lock.
                    if (bit_cnt == 3'd7) begin
                        if (w == COM) begin
                            if (com_cnt + 4'd1 == COM_TARGET) begin
                                state   <= ACTIVE;
                                active  <= 1'b1;
                                com_cnt <= 4'd0;
                            end else begin
                                com_cnt <= com_cnt + 4'd1;
                            end
                        end else begin
                            state   <= SEARCH;
                            com_cnt <= 4'd0;
                            bit_cnt <= 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_strobe <= 1'b1;
                        if (w != COM) begin
                            data_out  <= w;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end else begin
                        byte_strobe <= 1'b0;
                    end
                end
                default: begin
                    state       <= SEARCH;
                    bit_cnt     <= 3'd0;
                    com_cnt     <= 4'd0;
                    byte_strobe <= 1'b0;
                    active      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/phy_rx_serial_paralelo.md
Name: phy_rx_serial_paralelo

Overview:
- Receive-side serial-to-parallel converter for the PHY lane. It is the counterpart of the transmit parallel-to-serial stage.
- Accepts one bit per clk_32f cycle, MSB first.
- Hunts for the COM symbol at any bit offset, then locks byte alignment once COM has been seen COM_COUNT times in a row on byte boundaries.
- After lock, delivers each 8-bit byte plus a valid flag to the receive-side demux. COM bytes are idle fill and are marked invalid.

Parameters:
- COM, 8'hBC, comma/idle symbol sent by the transmitter whenever it has no valid data.
- COM_COUNT, 4, number of consecutive byte-aligned COM symbols needed to declare the link active (legal range 1..15).

Ports:
- clk_32f, input, 1, bit clock; all logic samples on the rising edge.
- reset_L, input, 1, asynchronous active-low reset.
- data_in, input, 1, serial bit stream, MSB of each byte first.
- data_out, output, 8, last completed non-idle byte after lock.
- valid_out, output, 1, data_out holds a data byte (not COM).
- byte_strobe, output, 1, one-cycle pulse on each byte boundary while ACTIVE.
- active, output, 1, byte alignment locked.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=SEARCH; shift register sr=0; bit_cnt=0; com_cnt=0.
  - data_out=8'h00; valid_out=0; byte_strobe=0; active=0.
  - Reset asserted mid-operation discards any partial byte and any lock immediately. After release, the block re-hunts from SEARCH.
- Every cycle:
  - sr <= {sr[6:0], data_in}.
  - The candidate word is w = {sr[6:0], data_in}, i.e. the 8 most recent bits including the current one.
- SEARCH:
  - Evaluated every cycle, so any bit offset is found.
  - If w==COM: go to ALIGN, com_cnt<=1, bit_cnt<=0.
  - If w==COM and COM_COUNT==1: go directly to ACTIVE and apply the ACTIVE-entry actions below.
  - Otherwise stay; counters hold at 0.
- ALIGN:
  - bit_cnt increments mod 8.
  - When bit_cnt==7, a byte is complete; evaluate w:
    - w==COM and com_cnt+1==COM_COUNT: go to ACTIVE, active<=1, com_cnt<=0.
    - w==COM otherwise: com_cnt<=com_cnt+1.
    - w!=COM: go back to SEARCH, com_cnt<=0, bit_cnt<=0.
  - A COM that appears only off-boundary in ALIGN is ignored.
- ACTIVE:
  - bit_cnt increments mod 8 and continues the phase established in ALIGN.
  - At bit_cnt==7: byte_strobe<=1.
    - w!=COM: data_out<=w, valid_out<=1.
    - w==COM: valid_out<=0, data_out holds its previous value.
  - At every other cycle: byte_strobe<=0; data_out and valid_out hold.
  - ACTIVE is sticky; only reset_L leaves it. There is no loss-of-sync detection in this revision.
  - active stays 1 for the whole ACTIVE state.
- Latency:
  - The last bit of a byte is sampled at edge N. data_out, valid_out and byte_strobe are visible after edge N: one cycle after that bit is on the line, and 8 cycles after the byte's first bit.
- Byte-boundary timing:
  - The first ACTIVE byte boundary is exactly 8 cycles after the edge at which active rose.
  - byte_strobe period is exactly 8 cycles while ACTIVE.
- Simultaneous events:
  - The lock-completing COM sets active but does not pulse byte_strobe and does not touch valid_out.
  - Data bytes that precede lock are never delivered.
- Widths: bit_cnt 3 bits, wraps 7->0. com_cnt 4 bits and never exceeds COM_COUNT-1.

Test Plan:
- Reset and lock:
  - Stimulus: hold reset_L=0 for 3 cycles, release, then send BC,BC,BC,BC,then data 8'h5A.
  - Response: all outputs 0 during reset. active=1 after the last bit of the 4th BC. One cycle after 5A's last bit: data_out=8'h5A, valid_out=1, byte_strobe=1 for 1 cycle.
- Arbitrary bit offset:
  - Stimulus: prepend 3 random bits (3'b101), then BC×4, then 8'hFF.
  - Response: lock is achieved, and data_out=8'hFF after 3+40 bits.
- Broken COM run:
  - Stimulus: BC,BC,8'h00,BC,BC,BC,BC,8'h33.
  - Response: returns to SEARCH at the 00 byte; active rises only after the 7th byte; data_out=8'h33.
- Idle fill while ACTIVE:
  - Stimulus: after lock, send 8'hA1,BC,8'hC2.
  - Response: valid_out=1 with A1, then valid_out=0 with data_out=A1 held, then valid_out=1 with C2. byte_strobe pulses every 8 cycles.
- Reset mid-operation:
  - Stimulus: assert reset_L=0 asynchronously mid-byte while ACTIVE.
  - Response: active=0, data_out=0, valid_out=0 immediately. Re-lock requires 4 fresh aligned BCs.
- COM_COUNT=1:
  - Stimulus: instantiate with COM_COUNT=1 and send BC,8'h7E.
  - Response: active=1 after the first BC; data_out=8'h7E, valid_out=1.
